cpu_bus_memory: RTL and testbench
=================================

# cpu_bus_memory

Program-memory and output-capture stage for the 6-bit TinyTapeout accumulator CPU. It decodes the CPU's 8-bit output bus, which carries either a tag `00` word with a fetch address or a tag `10` word with an output value. For an address word it returns the addressed program word on the CPU's 6-bit memory input in the same cycle. Output words are captured into a small FIFO that a host drains through a valid/ready handshake. The host also loads the program through this block while the block holds the CPU in reset.

## Interface
Parameters:
- `DEPTH`, 64, number of program words (equals 2^`ADDR_W`)
- `ADDR_W`, 6, address width
- `DATA_W`, 6, program/output word width
- `FIFO_DEPTH`, 4, output FIFO entries (power of two)

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge
- `reset_n`  in  1  synchronous, active-low reset
- `cpu_bus`  in  8  CPU output bus; [7:6] is the tag, [5:0] is the payload
- `cpu_data`  out  6  program word driven to the CPU memory input
- `cpu_reset`  out  1  active-high reset to the CPU
- `load_mode`  in  1  host program-load mode
- `load_valid`  in  1  write strobe; honoured only while `load_mode`=1
- `load_addr`  in  6  write address
- `load_data`  in  6  write data
- `out_valid`  out  1  FIFO head is valid
- `out_data`  out  6  FIFO head value
- `out_ready`  in  1  host accepts the head
- `fifo_count`  out  3  number of FIFO entries, 0..`FIFO_DEPTH`
- `overflow`  out  1  sticky flag: a captured output word was dropped
- `bus_error`  out  1  sticky flag: an illegal tag (`01` or `11`) was seen
- `flag_clr`  in  1  clears `overflow` and `bus_error`

## Operation
- **Reset** (`reset_n`=0 at an edge):
  - all memory words become 0 (0 is a CPU no-op);
  - FIFO emptied, `fifo_count`=0, `out_valid`=0, `out_data`=0;
  - `overflow`=0, `bus_error`=0, `cpu_reset`=1;
  - last-address register = 0, previous-tag register = `00`.
- **Bus decode by `cpu_bus[7:6]`:**
  - `00`: the word is an address. Combinationally, `cpu_data` = mem[`cpu_bus[5:0]`]. The last-address register loads the address.
  - `10`: the word is an output value. `cpu_data` = mem[last-address], so the CPU input stays stable.
  - `01` or `11`: treated as `10` for `cpu_data`. `bus_error` is set at the edge.
- **Output capture:**
  - A push occurs at an edge where the tag is `10` and the previous-tag register was not `10` (tag rising). A tag held at `10` for several cycles yields exactly one capture.
  - If the FIFO is full and no pop occurs at the same edge, the word is dropped and `overflow` is set.
- **FIFO handshake:**
  - A pop occurs at an edge where `out_valid`=1 and `out_ready`=1.
  - A push and a pop at the same edge are both performed, including when the FIFO is full; `overflow` is not set in that case.
  - There is no bypass: a push into an empty FIFO makes `out_valid` rise after that edge.
  - `out_data` is meaningful only while `out_valid`=1.
- **Program loading:**
  - While `load_mode`=1, each edge with `load_valid`=1 writes mem[`load_addr`] = `load_data`.
  - `load_valid` is ignored while `load_mode`=0.
- **CPU reset control:**
  - `cpu_reset` is a registered copy of (`!reset_n` | `load_mode`).
  - The CPU therefore leaves reset one edge after `load_mode` falls and then fetches from address 0.
- **Flags:** `flag_clr` at an edge clears both flags. If a setting event occurs at the same edge, the set wins.
- **Width rule:** FIFO pointers wrap modulo `FIFO_DEPTH`. `fifo_count` holds 0..4 without wrapping.

## Timing
- `cpu_data` is combinational from `cpu_bus` and the memory array, so the CPU samples a word fetched in the same cycle.
- A write is visible on `cpu_data` from the cycle after its edge. A write and a read of the same address in one cycle return the old word.
- Capture-to-`out_valid` latency is 1 edge.
- A pop updates `out_data`/`out_valid` after the edge.
- `reset_n` low mid-load or mid-capture:
  - memory is cleared;
  - the FIFO is flushed;
  - the write or capture at that edge is discarded.
- `load_mode` rising mid-program forces `cpu_reset`=1 after the next edge; FIFO contents are kept.

## Test plan
- **Reset:** assert `reset_n`=0 for 2 cycles with `cpu_bus`=8'h05 -> `cpu_data`=0, `cpu_reset`=1, `fifo_count`=0, `out_valid`=0, both flags 0.
- **Load then fetch:** `load_mode`=1, write addr 0..3 = 1,2,16,5 -> drop `load_mode`; `cpu_reset` falls after 1 edge; `cpu_bus`=8'h02 gives `cpu_data`=16 in the same cycle; with `load_mode`=0, writing 9 to addr 2 leaves `cpu_data`=16.
- **Output capture:** `cpu_bus`=8'h8D for 1 cycle, then 8'h03 -> `out_valid`=1 with `out_data`=13 after that edge; `cpu_data` during the 8'h8D cycle equals mem[last address]; 8'h8D held for 3 cycles -> `fifo_count` increases by 1 only.
- **Overflow:** 5 separated output words 1..5 with `out_ready`=0 -> `fifo_count`=4, `overflow`=1, pops return 1,2,3,4; `flag_clr` -> `overflow`=0.
- **Full, simultaneous push and pop:** FIFO full with values 1..4, push 7 with `out_ready`=1 at the same edge -> `fifo_count` stays 4, `overflow`=0, next heads are 2,3,4,7.
- **Illegal tag and mid-operation reset:** `cpu_bus`=8'h45 -> `bus_error`=1 and no push; `reset_n`=0 with 2 entries queued -> `fifo_count`=0 and mem[0..3] read 0.

Source files
------------

// File: rtl/cpu_bus_memory.sv
// Program memory and output-capture FIFO for the 6-bit accumulator CPU.
// Decodes the CPU bus, serves fetches combinationally, queues output words.
module cpu_bus_memory #(
   parameter int DEPTH      = 64,
   parameter int ADDR_W     = 6,
   parameter int DATA_W     = 6,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic [7:0]                    cpu_bus,
   output logic [DATA_W-1:0]             cpu_data,
   output logic                          cpu_reset,
   input  logic                          load_mode,
   input  logic                          load_valid,
   input  logic [ADDR_W-1:0]             load_addr,
   input  logic [DATA_W-1:0]             load_data,
   output logic                          out_valid,
   output logic [DATA_W-1:0]             out_data,
   input  logic                          out_ready,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          overflow,
   output logic                          bus_error,
   input  logic                          flag_clr
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
   localparam logic [1:0] TAG_ADDR = 2'b00;
   localparam logic [1:0] TAG_OUT  = 2'b10;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] fifo_q [FIFO_DEPTH];

   logic [ADDR_W-1:0] last_addr_q, last_addr_d;
   logic [1:0]        prev_tag_q, prev_tag_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              overflow_q, overflow_d;
   logic              bus_err_q, bus_err_d;
   logic              cpu_reset_q, cpu_reset_d;

   logic [1:0]        tag;
   logic              is_addr;
   logic              is_illegal;
   logic              push;
   logic              pop;
   logic              full;
   logic              wr_en;
   logic              drop;
   logic              mem_we;
   logic [ADDR_W-1:0] rd_addr;

   assign tag        = cpu_bus[7:6];
   assign is_addr    = (tag == TAG_ADDR);
   assign is_illegal = tag[0];
   assign mem_we     = load_mode && load_valid;

   // Fetch path: address words index directly, anything else holds the last address.
   always_comb begin
      rd_addr = last_addr_q;
      if (is_addr) begin
         rd_addr = cpu_bus[ADDR_W-1:0];
      end
   end

   assign cpu_data   = mem_q[rd_addr];
   assign out_valid  = (count_q != '0);
   assign out_data   = fifo_q[rd_ptr_q];
   assign fifo_count = count_q;
   assign overflow   = overflow_q;
   assign bus_error  = bus_err_q;
   assign cpu_reset  = cpu_reset_q;

   // Next-state for bus tracking, FIFO control and sticky flags.
   always_comb begin
      last_addr_d = last_addr_q;
      prev_tag_d  = tag;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      overflow_d  = overflow_q;
      bus_err_d   = bus_err_q;
      cpu_reset_d = load_mode;

      push  = (tag == TAG_OUT) && (prev_tag_q != TAG_OUT);
      pop   = out_valid && out_ready;
      full  = (count_q == FULL_CNT);
      wr_en = push && (!full || pop);
      drop  = push && full && !pop;

      if (is_addr) begin
         last_addr_d = cpu_bus[ADDR_W-1:0];
      end

      if (wr_en) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end

      unique case ({wr_en, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase

      if (flag_clr) begin
         overflow_d = 1'b0;
         bus_err_d  = 1'b0;
      end
      if (drop) begin
         overflow_d = 1'b1;
      end
      if (is_illegal) begin
         bus_err_d = 1'b1;
      end
   end

   // Control registers; reset holds the CPU in reset and empties the FIFO.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         last_addr_q <= '0;
         prev_tag_q  <= TAG_ADDR;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         bus_err_q   <= 1'b0;
         cpu_reset_q <= 1'b1;
      end else begin
         last_addr_q <= last_addr_d;
         prev_tag_q  <= prev_tag_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         overflow_q  <= overflow_d;
         bus_err_q   <= bus_err_d;
         cpu_reset_q <= cpu_reset_d;
      end
   end

   // Program memory: cleared to no-ops on reset, written by the host in load mode.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (mem_we) begin
         mem_q[load_addr] <= load_data;
      end
   end

   // Output FIFO storage; entries cleared on reset so out_data reads 0.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            fifo_q[i] <= '0;
         end
      end else if (wr_en) begin
         fifo_q[wr_ptr_q] <= cpu_bus[DATA_W-1:0];
      end
   end

endmodule

// File: tb/tb_cpu_bus_memory.sv
// Bench for cpu_bus_memory: directed stimulus, output words checked
// against a queue of expected values by an independent monitor.
module tb_cpu_bus_memory;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [7:0] cpu_bus;
   logic [5:0] cpu_data;
   logic       cpu_reset;
   logic       load_mode;
   logic       load_valid;
   logic [5:0] load_addr;
   logic [5:0] load_data;
   logic       out_valid;
   logic [5:0] out_data;
   logic       out_ready;
   logic [2:0] fifo_count;
   logic       overflow;
   logic       bus_error;
   logic       flag_clr;

   int total = 0;
   int bad   = 0;
   logic [5:0] sb_q [$];

   cpu_bus_memory dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .cpu_bus    (cpu_bus),
      .cpu_data   (cpu_data),
      .cpu_reset  (cpu_reset),
      .load_mode  (load_mode),
      .load_valid (load_valid),
      .load_addr  (load_addr),
      .load_data  (load_data),
      .out_valid  (out_valid),
      .out_data   (out_data),
      .out_ready  (out_ready),
      .fifo_count (fifo_count),
      .overflow   (overflow),
      .bus_error  (bus_error),
      .flag_clr   (flag_clr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Issue one output word followed by an address word so the tag re-arms.
   task automatic out_word(input logic [5:0] v, input bit expect_push);
      cpu_bus = {2'b10, v};
      if (expect_push) sb_q.push_back(v);
      step();
      cpu_bus = 8'h00;
      step();
   endtask

   task automatic drain();
      out_ready = 1'b1;
      for (int i = 0; i < 20 && fifo_count != 0; i++) step();
      out_ready = 1'b0;
      chk("drain_empty", fifo_count, 0);
   endtask

   // Monitor: a handshake seen mid-cycle completes at the next rising edge.
   always @(negedge clk) begin
      if (reset_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
         if (sb_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL sb_unexpected: got %0d expected none", out_data);
         end else begin
            chk("sb_data", out_data, sb_q.pop_front());
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [5:0] vals [4];
      vals[0] = 6'd1; vals[1] = 6'd2; vals[2] = 6'd16; vals[3] = 6'd5;

      reset_n = 1'b0; cpu_bus = 8'h05; load_mode = 1'b0; load_valid = 1'b0;
      load_addr = '0; load_data = '0; out_ready = 1'b0; flag_clr = 1'b0;
      step();
      step();
      chk("rst_cpu_data", cpu_data, 0);
      chk("rst_cpu_reset", cpu_reset, 1);
      chk("rst_count", fifo_count, 0);
      chk("rst_valid", out_valid, 0);
      chk("rst_ovf", overflow, 0);
      chk("rst_berr", bus_error, 0);

      // Load program then release the CPU.
      reset_n = 1'b1;
      cpu_bus = 8'h00;
      load_mode = 1'b1;
      load_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         load_addr = 6'(i);
         load_data = vals[i];
         step();
      end
      load_valid = 1'b0;
      chk("load_cpu_reset_hi", cpu_reset, 1);
      load_mode = 1'b0;
      step();
      chk("load_cpu_reset_lo", cpu_reset, 0);
      cpu_bus = 8'h02;
      #1;
      chk("fetch_addr2", cpu_data, 16);
      load_valid = 1'b1; load_addr = 6'd2; load_data = 6'd9;
      step();
      load_valid = 1'b0;
      chk("ignored_write", cpu_data, 16);

      // Single capture; cpu_data holds mem[last address] meanwhile.
      cpu_bus = 8'h8D;
      #1;
      chk("out_cpu_data", cpu_data, 16);
      sb_q.push_back(6'd13);
      step();
      cpu_bus = 8'h03;
      chk("cap_valid", out_valid, 1);
      chk("cap_count", fifo_count, 1);
      drain();

      // Held output tag captures once.
      cpu_bus = 8'h8D;
      sb_q.push_back(6'd13);
      step(); step(); step();
      cpu_bus = 8'h03;
      step();
      chk("held_count", fifo_count, 1);
      drain();

      // Overflow: fifth word is dropped.
      for (int v = 1; v <= 5; v++) out_word(6'(v), v <= 4);
      chk("ovf_count", fifo_count, 4);
      chk("ovf_flag", overflow, 1);
      drain();
      flag_clr = 1'b1;
      step();
      flag_clr = 1'b0;
      chk("ovf_clr", overflow, 0);

      // Full FIFO with push and pop at the same edge.
      for (int v = 1; v <= 4; v++) out_word(6'(v), 1'b1);
      chk("full_count", fifo_count, 4);
      cpu_bus = 8'h87;
      sb_q.push_back(6'd7);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      cpu_bus = 8'h00;
      chk("pp_count", fifo_count, 4);
      chk("pp_ovf", overflow, 0);
      drain();

      // Illegal tag; set wins over a simultaneous clear.
      cpu_bus = 8'h45;
      step();
      cpu_bus = 8'h00;
      chk("berr_set", bus_error, 1);
      chk("berr_nopush", fifo_count, 0);
      cpu_bus = 8'hC5;
      flag_clr = 1'b1;
      step();
      chk("berr_set_wins", bus_error, 1);
      cpu_bus = 8'h00;
      step();
      flag_clr = 1'b0;
      chk("berr_clr", bus_error, 0);

      // Reset with entries queued and a capture/write at the same edge.
      out_word(6'd10, 1'b0);
      out_word(6'd20, 1'b0);
      chk("mid_count", fifo_count, 2);
      reset_n = 1'b0;
      cpu_bus = 8'h9F;
      load_mode = 1'b1; load_valid = 1'b1; load_addr = 6'd1; load_data = 6'd33;
      step();
      reset_n = 1'b1;
      load_mode = 1'b0; load_valid = 1'b0;
      cpu_bus = 8'h00;
      chk("mid_rst_count", fifo_count, 0);
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_cpu_reset", cpu_reset, 1);
      for (int a = 0; a < 4; a++) begin
         cpu_bus = 8'(a);
         #1;
         chk("mid_rst_mem", cpu_data, 0);
      end
      step();
      chk("sb_left", sb_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
